// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encodings and index-width helper for the data memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Number of bits needed to index a word array of the given depth.
    function automatic int unsigned dmem_idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DATA_W word store, synchronous write, combinational read, no reset
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read is combinational so a same-edge write is never visible to the access that caused it.
    assign rdata_o = mem_q[idx_i];

    // Contents survive reset; only the write port updates them.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder; optional DMEM_MISALIGN_CHECK_EN adds rsp_err
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_write,
    input  logic              req_read,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int IDX_W = dmem_idx_width(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              init_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q, read_q, mis_q;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    logic              capture;
    logic              do_access;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_write, acc_read, acc_mis;
    logic              req_mis;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr;

    // Only the word-index bits (and, with the check, the byte offset) matter.
    assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_mis = (req_addr[1:0] != 2'b00);
    assign rsp_err = rsp_err_q;
`else
    assign req_mis = 1'b0;
`endif

    assign req_ready = init_q && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .we_i    (do_access && acc_write && !acc_mis),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    // Next-state, latency countdown and response value; the access fires on the final edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef DMEM_MISALIGN_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        capture     = 1'b0;
        do_access   = 1'b0;
        acc_idx     = idx_q;
        acc_wdata   = wdata_q;
        acc_write   = write_q;
        acc_read    = read_q;
        acc_mis     = mis_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency bypasses BUSY and uses the live request.
                        do_access = 1'b1;
                        acc_idx   = req_addr[2 +: IDX_W];
                        acc_wdata = req_wdata;
                        acc_write = req_write;
                        acc_read  = req_read;
                        acc_mis   = req_mis;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
`ifdef DMEM_MISALIGN_CHECK_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_access) begin
            // Writes win over reads; no-ops and misaligned accesses return zero.
            rsp_rdata_d = (acc_read && !acc_write && !acc_mis) ? arr_rdata : '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            rsp_err_d   = acc_mis;
`endif
        end
    end

    // State, counter and response registers; reset abandons any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            init_q      <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_q      <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_MISALIGN_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Request capture so req_* need not be held after acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else if (capture) begin
            idx_q   <= req_addr[2 +: IDX_W];
            wdata_q <= req_wdata;
            write_q <= req_write;
            read_q  <= req_read;
            mis_q   <= req_mis;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        req_read;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (64),
        .LATENCY (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_read  (req_read),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full request/response exchange; returns data, edges to rsp_valid and error flag.
    task automatic do_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input logic rd,
                          output logic [31:0] rdata, output int lat, output logic err);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_addr  = addr;
        req_wdata = wdata;
        req_write = wr;
        req_read  = rd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = rsp_rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
        err = rsp_err;
`else
        err = 1'b0;
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_after"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        err;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        req_read  = 1'b0;
        rsp_ready = 1'b0;

        #2;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rel_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Write 0x11 to 0x08, then read it back.
        do_req("wr08", 32'h08, 32'h11, 1'b1, 1'b0, rd, lat, err);
        chk("wr08_lat", lat, 32'd3);
        chk("wr08_rdata", rd, 32'd0);
        do_req("rd08", 32'h08, 32'h0, 1'b0, 1'b1, rd, lat, err);
        chk("rd08_lat", lat, 32'd3);
        chk("rd08_rdata", rd, 32'h11);

        // Prior contents of 0x20, then reset while a write of DEADBEEF is in BUSY.
        do_req("wr20", 32'h20, 32'h1234_5678, 1'b1, 1'b0, rd, lat, err);
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        req_write = 1'b1;
        req_read  = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midbusy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midbusy_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        do_req("rd20", 32'h20, 32'h0, 1'b0, 1'b1, rd, lat, err);
        chk("rd20_rdata", rd, 32'h1234_5678);

        // Backpressure on a read of 0x08; a stray store during RESP must be ignored.
        req_addr  = 32'h08;
        req_write = 1'b0;
        req_read  = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_lat", lat, 32'd3);
        req_addr  = 32'h08;
        req_wdata = 32'h99;
        req_write = 1'b1;
        req_read  = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h11);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_hs_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
        do_req("rd08b", 32'h08, 32'h0, 1'b0, 1'b1, rd, lat, err);
        chk("rd08b_rdata", rd, 32'h11);

        // Address wrap modulo DEPTH*4.
        do_req("wr104", 32'h104, 32'hA5, 1'b1, 1'b0, rd, lat, err);
        do_req("rd004", 32'h004, 32'h0, 1'b0, 1'b1, rd, lat, err);
        chk("wrap_rdata", rd, 32'hA5);

        // Write and read both set: write wins, response data is zero.
        do_req("wr_rd10", 32'h10, 32'h7, 1'b1, 1'b1, rd, lat, err);
        chk("wr_rd10_rdata", rd, 32'd0);
        do_req("rd10", 32'h10, 32'h0, 1'b0, 1'b1, rd, lat, err);
        chk("rd10_rdata", rd, 32'h7);

        // No-op is still acknowledged with zero data.
        do_req("noop", 32'h08, 32'h0, 1'b0, 1'b0, rd, lat, err);
        chk("noop_lat", lat, 32'd3);
        chk("noop_rdata", rd, 32'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
        do_req("mis0a", 32'h0A, 32'hFF, 1'b1, 1'b0, rd, lat, err);
        chk("mis0a_err", {31'd0, err}, 32'd1);
        chk("mis0a_lat", lat, 32'd3);
        chk("mis0a_rdata", rd, 32'd0);
        do_req("rd08c", 32'h08, 32'h0, 1'b0, 1'b1, rd, lat, err);
        chk("rd08c_rdata", rd, 32'h11);
        chk("rd08c_err", {31'd0, err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
